// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: MMIO bridge between CPU data port and UART with TX/RX FIFOs, status words and cycle/instruction counters
module uart_mmio_ctrl #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [31:0] cpu_rdata,
  input  logic        inst_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);
  localparam int TW = $clog2(TX_DEPTH);
  localparam int RW = $clog2(RX_DEPTH);
  localparam logic [TW:0] TX_FULL_CNT = (TW + 1)'(TX_DEPTH);
  localparam logic [RW:0] RX_FULL_CNT = (RW + 1)'(RX_DEPTH);
  localparam logic [31:0] A_TS = 32'h8000_0000;
  localparam logic [31:0] A_RS = 32'h8000_0004;
  localparam logic [31:0] A_TX = 32'h8000_0008;
  localparam logic [31:0] A_RX = 32'h8000_000C;
  localparam logic [31:0] A_CY = 32'h8000_0010;
  localparam logic [31:0] A_IN = 32'h8000_0014;
  localparam logic [31:0] A_CL = 32'h8000_0018;
  logic [7:0]    tx_mem [TX_DEPTH];
  logic [7:0]    rx_mem [RX_DEPTH];
  logic [TW-1:0] tx_wp, tx_rp;
  logic [RW-1:0] rx_wp, rx_rp;
  logic [TW:0]   tx_cnt;
  logic [RW:0]   rx_cnt;
  logic          ovf;
  logic [31:0]   cyc, inst;
  logic tx_full, rx_full, rx_ne, tx_push_req, tx_push, tx_pop, rx_cap, rx_pop, ts_wr, clr;
  logic unused_wdata;
  assign unused_wdata = ^cpu_wdata[31:8];
  assign tx_full     = tx_cnt == TX_FULL_CNT;
  assign rx_full     = rx_cnt == RX_FULL_CNT;
  assign rx_ne       = rx_cnt != '0;
  assign tx_valid    = !reset && tx_cnt != '0;
  assign tx_data     = tx_mem[tx_rp];
  assign rx_ready    = !reset && !rx_full;
  assign tx_push_req = !reset && cpu_we && cpu_addr == A_TX;
  assign tx_push     = tx_push_req && !tx_full;
  assign tx_pop      = tx_valid && tx_ready;
  assign rx_cap      = rx_valid && rx_ready;
  assign rx_pop      = !reset && cpu_re && cpu_addr == A_RX && rx_ne;
  assign ts_wr       = cpu_we && cpu_addr == A_TS;
  assign clr         = cpu_we && cpu_addr == A_CL;
  always_comb begin
    cpu_rdata = reset               ? 32'h0 :
                cpu_addr == A_TS    ? {30'h0, ovf, !tx_full} :
                cpu_addr == A_RS    ? {30'h0, rx_full, rx_ne} :
                cpu_addr == A_RX    ? (rx_ne ? {24'h0, rx_mem[rx_rp]} : 32'h0) :
                cpu_addr == A_CY    ? cyc :
                cpu_addr == A_IN    ? inst : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= cpu_wdata[7:0];
    if (rx_cap) rx_mem[rx_wp] <= rx_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
      ovf    <= 1'b0;
      cyc    <= '0;
      inst   <= '0;
    end else begin
      tx_wp  <= tx_push ? tx_wp + TW'(1) : tx_wp;
      tx_rp  <= tx_pop ? tx_rp + TW'(1) : tx_rp;
      tx_cnt <= tx_cnt + (TW + 1)'(tx_push) - (TW + 1)'(tx_pop);
      rx_wp  <= rx_cap ? rx_wp + RW'(1) : rx_wp;
      rx_rp  <= rx_pop ? rx_rp + RW'(1) : rx_rp;
      rx_cnt <= rx_cnt + (RW + 1)'(rx_cap) - (RW + 1)'(rx_pop);
      ovf    <= ts_wr ? 1'b0 : ovf || (tx_push_req && tx_full);
      cyc    <= clr ? '0 : cyc + 32'd1;
      inst   <= clr ? '0 : inst + 32'(inst_valid);
    end
  end
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb_uart_mmio_ctrl: table-driven and directed checks of uart_mmio_ctrl
module tb_uart_mmio_ctrl;
  localparam logic [31:0] A_TS = 32'h8000_0000;
  localparam logic [31:0] A_RS = 32'h8000_0004;
  localparam logic [31:0] A_TX = 32'h8000_0008;
  localparam logic [31:0] A_RX = 32'h8000_000C;
  localparam logic [31:0] A_CY = 32'h8000_0010;
  localparam logic [31:0] A_IN = 32'h8000_0014;
  localparam logic [31:0] A_CL = 32'h8000_0018;
  logic        clk, reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_we, cpu_re, inst_valid;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic        we, re;
    logic [31:0] addr, wdata;
    logic        txr, rxv;
    logic [7:0]  rxd;
    logic [31:0] erd;
    logic        etxv;
    logic [7:0]  etxd;
    logic        erxr;
  } vec_t;
  vec_t vecs[$];
  uart_mmio_ctrl #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_rdata(cpu_rdata), .inst_valid(inst_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] wd, input logic txr, input logic rxv,
                       input logic [7:0] rxd, input logic iv);
    @(negedge clk);
    reset = r;
    cpu_we = we;
    cpu_re = re;
    cpu_addr = a;
    cpu_wdata = wd;
    tx_ready = txr;
    rx_valid = rxv;
    rx_data = rxd;
    inst_valid = iv;
    #1;
  endtask
  function automatic void v(input logic we, input logic re, input logic [31:0] a,
                            input logic [31:0] wd, input logic txr, input logic rxv,
                            input logic [7:0] rxd, input logic [31:0] erd,
                            input logic etxv, input logic [7:0] etxd, input logic erxr);
    vec_t t;
    t.we = we; t.re = re; t.addr = a; t.wdata = wd; t.txr = txr; t.rxv = rxv;
    t.rxd = rxd; t.erd = erd; t.etxv = etxv; t.etxd = etxd; t.erxr = erxr;
    vecs.push_back(t);
  endfunction
  initial begin
    reset = 1'b1; cpu_we = 0; cpu_re = 0; cpu_addr = 0; cpu_wdata = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0; inst_valid = 0;
    v(0,0,A_TS,0, 0,0,0, 32'h1, 0,0,1);
    v(0,0,A_RS,0, 0,0,0, 32'h0, 0,0,1);
    v(1,0,A_TX,32'h41, 0,0,0, 0, 0,0,1);
    v(1,0,A_TX,32'h42, 0,0,0, 0, 1,8'h41,1);
    v(1,0,A_TX,32'h43, 0,0,0, 0, 1,8'h41,1);
    v(0,0,A_TS,0, 0,0,0, 1, 1,8'h41,1);
    v(0,0,A_TS,0, 1,0,0, 1, 1,8'h41,1);
    v(0,0,A_TS,0, 1,0,0, 1, 1,8'h42,1);
    v(0,0,A_TS,0, 1,0,0, 1, 1,8'h43,1);
    v(0,0,A_TS,0, 1,0,0, 1, 0,0,1);
    v(1,0,A_TX,32'h60, 0,0,0, 0, 0,0,1);
    v(1,0,A_TX,32'h61, 1,0,0, 0, 1,8'h60,1);
    v(0,0,A_TS,0, 1,0,0, 1, 1,8'h61,1);
    v(0,0,A_TS,0, 1,0,0, 1, 0,0,1);
    for (int k = 0; k < 9; k++) v(1,0,A_TX,32'h50 + k, 0,0,0, 0, k != 0,8'h50,1);
    v(0,0,A_TS,0, 0,0,0, 2, 1,8'h50,1);
    v(1,0,A_TS,0, 0,0,0, 2, 1,8'h50,1);
    v(0,0,A_TS,0, 0,0,0, 0, 1,8'h50,1);
    v(1,0,A_TX,32'h59, 1,0,0, 0, 1,8'h50,1);
    v(0,0,A_TS,0, 0,0,0, 3, 1,8'h51,1);
    v(1,0,A_TS,0, 0,0,0, 3, 1,8'h51,1);
    v(0,0,A_TS,0, 0,0,0, 1, 1,8'h51,1);
    for (int k = 1; k < 8; k++) v(0,0,A_TS,0, 1,0,0, 1, 1,8'(8'h50 + k),1);
    v(0,0,A_TS,0, 1,0,0, 1, 0,0,1);
    for (int k = 0; k < 8; k++) v(0,0,A_RS,0, 0,1,8'(8'h10 + k), k > 0 ? 1 : 0, 0,0,1);
    v(0,0,A_RS,0, 0,1,8'h99, 3, 0,0,0);
    for (int k = 0; k < 8; k++) v(k == 3,1,A_RX,32'hFF, 0,0,0, 32'h10 + k, 0,0,k > 0);
    v(0,1,A_RX,0, 0,0,0, 0, 0,0,1);
    v(0,0,A_RS,0, 0,0,0, 0, 0,0,1);
    v(0,0,A_RS,0, 0,1,8'h20, 0, 0,0,1);
    v(0,1,A_RX,0, 0,1,8'h21, 32'h20, 0,0,1);
    v(0,1,A_RX,0, 0,0,0, 32'h21, 0,0,1);
    v(0,0,A_RS,0, 0,0,0, 0, 0,0,1);
    v(0,1,A_RX,0, 0,1,8'h30, 0, 0,0,1);
    v(0,0,A_RS,0, 0,0,0, 1, 0,0,1);
    v(0,0,A_RX,0, 0,0,0, 32'h30, 0,0,1);
    v(0,1,A_RX,0, 0,0,0, 32'h30, 0,0,1);
    v(0,0,A_RS,0, 0,0,0, 0, 0,0,1);
    v(0,0,A_RS,0, 0,1,8'h77, 0, 0,0,1);
    v(0,1,32'h0000_000C,0, 0,0,0, 0, 0,0,1);
    v(0,1,A_RX,0, 0,0,0, 32'h77, 0,0,1);
    v(0,0,32'h8000_0020,0, 0,0,0, 0, 0,0,1);
    v(1,0,32'h0000_0008,32'h88, 0,0,0, 0, 0,0,1);
    v(0,0,A_TS,0, 0,0,0, 1, 0,0,1);
    drive(1, 0,0,A_TS,0, 0,0,0, 0);
    chk("rst rdata", cpu_rdata, 0);
    chk("rst tx_valid", 32'(tx_valid), 0);
    chk("rst rx_ready", 32'(rx_ready), 0);
    drive(1, 1,0,A_TX,32'h77, 0,1,8'h55, 1);
    chk("rst push tx_valid", 32'(tx_valid), 0);
    foreach (vecs[i]) begin
      drive(0, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].txr,
            vecs[i].rxv, vecs[i].rxd, 0);
      chk($sformatf("v%0d rdata", i), cpu_rdata, vecs[i].erd);
      chk($sformatf("v%0d tx_valid", i), 32'(tx_valid), 32'(vecs[i].etxv));
      if (vecs[i].etxv) chk($sformatf("v%0d tx_data", i), 32'(tx_data), 32'(vecs[i].etxd));
      chk($sformatf("v%0d rx_ready", i), 32'(rx_ready), 32'(vecs[i].erxr));
    end
    drive(0, 1,0,A_CL,0, 0,0,0, 0);
    for (int k = 0; k < 100; k++) begin
      drive(0, 0,0,k == 1 ? A_IN : A_CY,0, 0,0,0, (k % 5) < 2);
      if (k == 0) chk("cyc after clear", cpu_rdata, 0);
      if (k == 1) chk("inst first", cpu_rdata, 1);
    end
    drive(0, 0,0,A_CY,0, 0,0,0, 0);
    chk("cyc 100", cpu_rdata, 100);
    drive(0, 0,0,A_IN,0, 0,0,0, 0);
    chk("inst 40", cpu_rdata, 40);
    drive(0, 1,0,A_CL,32'hDEAD, 0,0,0, 1);
    drive(0, 0,0,A_IN,0, 0,0,0, 1);
    chk("inst clear priority", cpu_rdata, 0);
    drive(0, 0,0,A_CY,0, 0,0,0, 0);
    chk("cyc resume", cpu_rdata, 1);
    drive(0, 0,0,A_IN,0, 0,0,0, 0);
    chk("inst resume", cpu_rdata, 1);
    for (int k = 0; k < 9; k++) drive(0, 1,0,A_TX,32'hA0 + k, 0,0,0, 1);
    for (int k = 0; k < 3; k++) drive(0, 0,0,A_RS,0, 0,1,8'(8'hB0 + k), 0);
    drive(0, 0,0,A_TS,0, 0,0,0, 0);
    chk("pre-rst status", cpu_rdata, 2);
    drive(0, 0,0,A_RS,0, 0,0,0, 0);
    chk("pre-rst rx status", cpu_rdata, 1);
    drive(1, 0,0,A_CY,0, 0,1,8'hCC, 1);
    chk("mid rst rdata", cpu_rdata, 0);
    chk("mid rst tx_valid", 32'(tx_valid), 0);
    chk("mid rst rx_ready", 32'(rx_ready), 0);
    drive(1, 1,0,A_TX,32'hDD, 1,1,8'hCC, 1);
    chk("mid rst tx_valid2", 32'(tx_valid), 0);
    drive(0, 0,0,A_TS,0, 1,0,0, 0);
    chk("post-rst status", cpu_rdata, 1);
    chk("post-rst tx_valid", 32'(tx_valid), 0);
    chk("post-rst rx_ready", 32'(rx_ready), 1);
    drive(0, 0,0,A_RS,0, 1,0,0, 0);
    chk("post-rst rx status", cpu_rdata, 0);
    drive(0, 0,0,A_CY,0, 1,0,0, 0);
    chk("post-rst cyc", cpu_rdata, 2);
    drive(0, 0,0,A_IN,0, 1,0,0, 0);
    chk("post-rst inst", cpu_rdata, 0);
    drive(0, 0,1,A_RX,0, 1,0,0, 0);
    chk("post-rst rx load", cpu_rdata, 0);
    chk("post-rst tx idle", 32'(tx_valid), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
- Memory-mapped I/O controller between the CPU data-memory port (addresses with bit 31 set) and the UART serializer.
- Buffers CPU stores to the transmit register in a TX FIFO and drains them to the UART under a ready/valid handshake.
- Buffers received bytes in an RX FIFO for CPU loads.
- Provides status words and cycle/instruction counters, so software does not busy-wait on every UART byte.

Parameters:
- TX_DEPTH, 8, TX FIFO entries; power of two, minimum 2.
- RX_DEPTH, 8, RX FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cpu_addr  input  32  byte address from the ALU result
- cpu_wdata  input  32  store data
- cpu_we  input  1  store strobe, one cycle per store
- cpu_re  input  1  load strobe, one cycle per load
- cpu_rdata  output  32  load data, combinational from current state
- inst_valid  input  1  one instruction retired this cycle
- tx_data  output  8  byte presented to the UART transmitter
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  UART transmitter accepts a byte
- rx_data  input  8  byte from the UART receiver
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  controller accepts rx_data

Behaviour:
- Reset:
  - Clears both FIFO pointers and counts, the overflow flag and both counters.
  - While reset is high: tx_valid=0, rx_ready=0, cpu_rdata=0, all strobes ignored.
  - Reset mid-transfer discards all FIFO contents.
- Address map: full 32-bit equality compare.
  - 0x80000000 read: bit0 = TX not full; bit1 = TX overflow flag (sticky); bits 31:2 = 0. Any write here clears the overflow flag.
  - 0x80000004 read: bit0 = RX not empty; bit1 = RX full; others 0.
  - 0x80000008 write: push cpu_wdata[7:0] into the TX FIFO.
  - 0x8000000C read: cpu_rdata = {24'b0, RX head}. The pop takes effect at the clock edge ending the load cycle. If RX is empty: cpu_rdata=0, no state change.
  - 0x80000010 read: cycle counter.
  - 0x80000014 read: instruction counter.
  - 0x80000018 write: clears both counters, whatever the data.
  - Any other address: reads return 0, writes are ignored.
- TX FIFO:
  - tx_valid = (tx_count != 0).
  - tx_data = TX head.
  - A transfer occurs on a cycle with tx_valid && tx_ready; the head pops at that edge.
  - A push on cycle N is visible on tx_valid/tx_data at N+1 at the earliest (one-cycle latency through an empty FIFO).
  - Full is evaluated from the count at the start of the cycle. A push while full is dropped and sets the overflow flag, even if a drain happens in the same cycle.
  - Simultaneous push and drain when not full: count is unchanged and both pointers advance.
  - Pointers wrap modulo depth.
- RX FIFO:
  - rx_ready = !reset && (rx_count != RX_DEPTH).
  - A byte is captured on a cycle with rx_valid && rx_ready.
  - Simultaneous capture and CPU pop: count is unchanged and the data order is preserved.
  - A pop in the same cycle a byte enters an empty FIFO returns 0; the new byte stays queued.
- Counters:
  - Both 32-bit, wrap 0xFFFFFFFF -> 0.
  - Cycle counter increments every non-reset cycle.
  - Instruction counter increments when inst_valid=1.
  - A clear write has priority over increment: value 0 at the next cycle, incrementing resumes after that.
- Strobes:
  - cpu_we and cpu_re high together: both act (write-decoded and read-decoded actions are independent).
  - cpu_rdata depends only on cpu_addr and state, not on cpu_re. Side effects require cpu_re.

Test Plan:
- Reset, then sample: tx_valid=0; rx_ready=1 one cycle after reset drops; read 0x80000000 -> 0x00000001; read 0x80000004 -> 0x00000000.
- Store 0x41, 0x42, 0x43 to 0x80000008 with tx_ready=0 -> tx_valid=1, tx_data=0x41. Raise tx_ready -> bytes 0x41, 0x42, 0x43 on consecutive cycles, then tx_valid=0.
- Push 9 bytes with tx_ready=0 (TX_DEPTH=8) -> 9th dropped, read 0x80000000 -> 0x00000002. Write 0x80000000 -> reads 0x00000000 (still full). One drain -> 0x00000001.
- Drive 8 RX bytes 0x10..0x17 -> rx_ready=0, 0x80000004 reads 0x3. Loads from 0x8000000C return 0x10..0x17 in order. A ninth load returns 0 and state is unchanged.
- Run 100 cycles with inst_valid high on 40 of them -> 0x80000010 reads 100 and 0x80000014 reads 40 (±1 per the sampling edge). Write 0x80000018 -> next cycle both read 0.
- Pulse reset with 5 TX and 3 RX entries queued -> both FIFOs empty, overflow cleared, counters 0, no further tx_valid.
